// File: rtl/gfx_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : gfx_mem_arbiter
// Brief  : Round-robin, hold-while-rts arbiter for fill_rect/draw_line/blit
//          onto one graphics-memory port, with tagged read-return broadcast.
// Rev    : 1.0  initial release
// ============================================================================
module gfx_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 64,
    parameter int RD_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NUM_REQ-1:0]     req_rts,
    output logic [NUM_REQ-1:0]     req_rtr,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [4*NUM_REQ-1:0]   req_wben,
    input  logic [16*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic                   mem_rts,
    input  logic                   mem_rtr,
    output logic                   mem_op,
    output logic [3:0]             mem_wben,
    output logic [15:0]            mem_addr,
    output logic [31:0]            mem_data,
    input  logic                   mem_rd_valid,
    input  logic [31:0]            mem_rd_data,
    output logic                   bcast_xfc,
    output logic [31:0]            bcast_data,
    output logic [1:0]             bcast_id,
    output logic                   rd_err
);

    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int AW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_gnt, r_last, w_gnt_nxt, w_pick;
    logic [CW-1:0]         r_burst_cnt;
    logic [1:0]            r_fifo [RD_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_fifo_cnt;
    logic                  r_rd_err;

    logic                  w_grant, w_rts_g, w_op_g, w_others, w_full, w_empty;
    logic                  w_rd_block, w_forced, w_release, w_rtr_g, w_xfc;
    logic                  w_push, w_pop, w_rd_valid, w_cnt_sat;
    logic [NUM_REQ-1:0]    w_gnt_1h;

    assign w_grant    = (r_state == S_GRANT);
    assign w_rts_g    = req_rts[r_gnt];
    assign w_op_g     = req_op[r_gnt];
    assign w_gnt_1h   = NUM_REQ'(1) << r_gnt;
    assign w_others   = |(req_rts & ~w_gnt_1h);
    assign w_full     = (r_fifo_cnt == (AW+1)'(RD_DEPTH));
    assign w_empty    = (r_fifo_cnt == '0);
    assign w_cnt_sat  = (MAX_BURST != 0) && (r_burst_cnt == CW'(MAX_BURST));

    assign w_rd_block = w_grant & w_op_g & w_full;
    assign w_forced   = w_cnt_sat & w_others;
    assign w_release  = w_grant & (~w_rts_g | w_forced);
    assign w_rtr_g    = w_grant & mem_rtr & ~w_rd_block & ~w_release;
    assign w_xfc      = w_rtr_g & w_rts_g;
    assign w_push     = w_xfc & w_op_g;

    // Read-return path is gated by reset so the broadcast bus is quiet in reset.
    assign w_rd_valid = mem_rd_valid & rst_;
    assign w_pop      = w_rd_valid & ~w_empty;

    assign req_rtr    = w_rtr_g ? w_gnt_1h : '0;
    assign mem_rts    = w_grant & w_rts_g & ~w_rd_block;
    assign mem_op     = w_grant ? w_op_g : 1'b0;
    assign mem_wben   = w_grant ? req_wben[4*r_gnt +: 4]   : 4'h0;
    assign mem_addr   = w_grant ? req_addr[16*r_gnt +: 16] : 16'h0;
    assign mem_data   = w_grant ? req_data[32*r_gnt +: 32] : 32'h0;

    assign bcast_xfc  = w_rd_valid;
    assign bcast_data = w_rd_valid ? mem_rd_data : 32'h0;
    assign bcast_id   = w_pop ? r_fifo[r_rd_ptr] : 2'b00;
    assign rd_err     = r_rd_err;

    // Lowest k wins: scan last+1, last+2, last+3 (mod NUM_REQ).
    always_comb begin
        w_pick = r_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_rts[(int'(r_last) + k) % NUM_REQ]) begin
                w_pick = 2'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (|req_rts) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = w_pick;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= S_IDLE;
            r_gnt       <= 2'd0;
            r_last      <= 2'd2;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            if (w_release) begin
                r_last      <= r_gnt;
                r_burst_cnt <= '0;
            end else if (w_xfc && !w_cnt_sat) begin
                r_burst_cnt <= r_burst_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
            else if (w_pop && !w_push) r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
            if (w_rd_valid && w_empty) r_rd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_gnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_gfx_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_gfx_mem_arbiter
// Brief  : Randomized requesters and memory against a queue-based arbiter
//          model; read returns are checked through an expected-id scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gfx_mem_arbiter;
    localparam int MAXB  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [2:0]  req_rts = '0, req_rtr, req_op = '0;
    logic [11:0] req_wben = '0;
    logic [47:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic        mem_rts, mem_rtr = 1'b0, mem_op;
    logic [3:0]  mem_wben;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        bcast_xfc, rd_err;
    logic [31:0] bcast_data;
    logic [1:0]  bcast_id;

    always #5 clk = ~clk;

    gfx_mem_arbiter #(.NUM_REQ(3), .MAX_BURST(MAXB), .RD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_),
        .req_rts(req_rts), .req_rtr(req_rtr), .req_op(req_op),
        .req_wben(req_wben), .req_addr(req_addr), .req_data(req_data),
        .mem_rts(mem_rts), .mem_rtr(mem_rtr), .mem_op(mem_op),
        .mem_wben(mem_wben), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .bcast_xfc(bcast_xfc), .bcast_data(bcast_data), .bcast_id(bcast_id),
        .rd_err(rd_err)
    );

    typedef struct { logic op; logic [3:0] wben; logic [15:0] addr; logic [31:0] data; } txn_t;
    typedef struct { int id; logic [31:0] data; } rd_exp_t;

    txn_t        cur [3];
    bit          active [3];
    bit          xfc_flag [3];
    rd_exp_t     exp_rd [$];
    logic [31:0] pending_ret [$];
    logic [31:0] mem_arr [32];

    int n_checks = 0, n_fail = 0;
    int owner = -1, last = 2, cnt = 0;
    bit err_exp = 1'b0;
    int ret_pct = 50, rtr_pct = 80, new_pct = 70;
    bit gen_en = 1'b1, force_spur = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.op   = ($urandom_range(0, 99) < 40);
        t.wben = 4'($urandom);
        t.addr = {11'h0, 5'($urandom)};
        t.data = $urandom;
        return t;
    endfunction

    task automatic pack_fields();
        for (int i = 0; i < 3; i++) begin
            req_rts[i]            = active[i];
            req_op[i]             = cur[i].op;
            req_wben[4*i +: 4]    = cur[i].wben;
            req_addr[16*i +: 16]  = cur[i].addr;
            req_data[32*i +: 32]  = cur[i].data;
        end
    endtask

    // One requester/memory cycle, driven just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (xfc_flag[i]) begin
                active[i]   = 1'b0;
                xfc_flag[i] = 1'b0;
            end
            if (!active[i] && gen_en && $urandom_range(0, 99) < new_pct) begin
                cur[i]    = rand_txn();
                active[i] = 1'b1;
            end
        end
        pack_fields();
        mem_rtr = ($urandom_range(0, 99) < rtr_pct);
        if (force_spur) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEAD_BEEF;
        end else if (pending_ret.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = pending_ret.pop_front();
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
        end
    endtask

    // Reference model and monitor: evaluated mid-cycle on settled inputs.
    always @(negedge clk) begin
        logic [2:0]  e_rtr;
        logic        e_mrts, rts_o, others, block, rel, spur;
        logic [52:0] e_fields;
        rd_exp_t     e;
        int          j, idx;
        if (!rst_) begin
            owner = -1; last = 2; cnt = 0; err_exp = 1'b0;
            exp_rd.delete();
            pending_ret.delete();
            for (int i = 0; i < 3; i++) xfc_flag[i] = 1'b0;
        end else begin
            e_rtr = '0; e_mrts = 1'b0; e_fields = '0; rel = 1'b0; spur = 1'b0;
            if (owner >= 0) begin
                rts_o  = req_rts[owner];
                others = 1'b0;
                for (int k = 0; k < 3; k++) if (k != owner && req_rts[k]) others = 1'b1;
                block  = cur[owner].op && (exp_rd.size() == DEPTH);
                rel    = !rts_o || (cnt >= MAXB && others);
                e_mrts = rts_o && !block;
                if (mem_rtr && !block && !rel) e_rtr[owner] = 1'b1;
                e_fields = {cur[owner].op, cur[owner].wben, cur[owner].addr, cur[owner].data};
            end
            check("req_rtr", req_rtr, e_rtr);
            check("mem_rts", mem_rts, e_mrts);
            check("mem_fields", {mem_op, mem_wben, mem_addr, mem_data}, e_fields);

            if (mem_rd_valid) begin
                check("bcast_xfc", bcast_xfc, 1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    check("bcast_id", bcast_id, e.id);
                    check("bcast_data", bcast_data, e.data);
                end else begin
                    check("bcast_id_spurious", bcast_id, 0);
                    check("bcast_data_spurious", bcast_data, mem_rd_data);
                    spur = 1'b1;
                end
            end else begin
                check("bcast_idle", bcast_xfc, 0);
            end
            check("rd_err", rd_err, err_exp);
            if (spur) err_exp = 1'b1;

            j = -1;
            for (int k = 0; k < 3; k++) if (req_rts[k] && req_rtr[k]) j = k;
            if (j >= 0) begin
                xfc_flag[j] = 1'b1;
                if (j == owner) cnt++;
                if (cur[j].op) begin
                    exp_rd.push_back('{id: j, data: mem_arr[cur[j].addr[4:0]]});
                    pending_ret.push_back(mem_arr[cur[j].addr[4:0]]);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (cur[j].wben[b]) mem_arr[cur[j].addr[4:0]][8*b +: 8] = cur[j].data[8*b +: 8];
                end
            end

            if (owner >= 0) begin
                if (rel) begin
                    last = owner; owner = -1; cnt = 0;
                end
            end else if (|req_rts) begin
                for (int k = 3; k >= 1; k--) begin
                    idx = (last + k) % 3;
                    if (req_rts[idx]) owner = idx;
                end
            end
        end
    end

    initial begin
        bit done;
        for (int i = 0; i < 32; i++) mem_arr[i] = 32'h0101_0101 * i;
        for (int i = 0; i < 3; i++) begin
            cur[i] = '{op: 1'b0, wben: 4'h0, addr: 16'h0, data: 32'h0};
            active[i] = 1'b0; xfc_flag[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_rtr", req_rtr, 0);
        check("reset_mem_rts", mem_rts, 0);
        check("reset_mem_fields", {mem_op, mem_wben, mem_addr, mem_data}, 0);
        check("reset_bcast", {bcast_xfc, bcast_data, bcast_id}, 0);
        check("reset_rd_err", rd_err, 0);
        rst_ = 1'b1;

        repeat (300) step();
        ret_pct = 5; rtr_pct = 90;
        repeat (300) step();

        gen_en = 1'b0; ret_pct = 100; rtr_pct = 100;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            done = !active[0] && !active[1] && !active[2] &&
                   pending_ret.size() == 0 && exp_rd.size() == 0 && !mem_rd_valid;
        end
        check("drain_complete", done, 1);

        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        repeat (3) step();
        check("rd_err_sticky", rd_err, 1);

        gen_en = 1'b1; new_pct = 100; ret_pct = 40; rtr_pct = 90;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            step();
            done = (req_rtr != 0);
        end
        check("burst_before_reset", done, 1);
        #2;
        rst_ = 1'b0;
        mem_rd_valid = 1'b1;
        #1;
        check("async_rst_req_rtr", req_rtr, 0);
        check("async_rst_mem_rts", mem_rts, 0);
        check("async_rst_mem_fields", {mem_op, mem_wben, mem_addr, mem_data}, 0);
        check("async_rst_bcast", {bcast_xfc, bcast_data, bcast_id}, 0);
        check("async_rst_rd_err", rd_err, 0);
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) active[i] = 1'b0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cur[i] = rand_txn();
            cur[i].op = 1'b0;
            active[i] = 1'b1;
        end
        pack_fields();
        mem_rtr = 1'b1;
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        check("first_grant_after_reset", req_rtr, 3'b001);
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
